// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, FSM encoding, rcon table and
// GF(2^8) helpers used by the round datapath and the key schedule.
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-expansion step: derives the next four round-key words from the
// previous four and a chosen last word (RotWord/rcon optional).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [31:0]  last_word,
  input  logic         rot_en,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] sel_word;
  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  always_comb begin
    sel_word = rot_en ? {last_word[23:0], last_word[31:24]} : last_word;
    temp     = {sbox(sel_word[31:24]) ^ rcon, sbox(sel_word[23:16]),
                sbox(sel_word[15:8]), sbox(sel_word[7:0])};
    w0       = prev_key[127:96] ^ temp;
    w1       = prev_key[95:64]  ^ w0;
    w2       = prev_key[63:32]  ^ w1;
    w3       = prev_key[31:0]   ^ w2;
    next_key = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per clock with an
// on-the-fly key schedule and valid/ready handshakes on both sides.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned RND_SIZE = 128,
  parameter int unsigned WRD_SIZE = 32,
  parameter int unsigned KEY_MAX  = 256,
  parameter int unsigned CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_key_256,
  input  logic [KEY_MAX-1:0]  i_key,
  input  logic [RND_SIZE-1:0] i_rnd_text,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [RND_SIZE-1:0] o_cypher_text,
  output logic                o_busy,
  output logic [CNT_SIZE-1:0] o_rnd_count
);

  state_t                state;
  logic [RND_SIZE-1:0]   state_reg;
  logic [2*RND_SIZE-1:0] key_win;
  logic                  mode_256;
  logic [CNT_SIZE-1:0]   cnt;

  logic                  sel_256;
  logic [RND_SIZE-1:0]   rk0, key_lo;
  logic [RND_SIZE-1:0]   win_a, win_b;
  logic [WRD_SIZE-1:0]   step_last;
  logic                  step_rot;
  logic [7:0]            step_rcon;
  logic [RND_SIZE-1:0]   step_key, rk_r;
  logic [RND_SIZE-1:0]   sb, sr, mc, rnd_out;
  logic [CNT_SIZE-1:0]   nr;
  logic                  last_rnd;

  assign sel_256 = i_key_256 && (KEY_MAX > RND_SIZE);
  assign rk0     = i_key[KEY_MAX-1 -: RND_SIZE];
  assign key_lo  = sel_256 ? i_key[RND_SIZE-1:0] : '0;

  assign o_ready     = rst_n && (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_rnd_count = cnt;

  // key_win = {A, B}: AES-128 only uses A; AES-256 slides the two most
  // recent round keys, with rk_1 already sitting in B.
  always_comb begin
    win_a     = key_win[2*RND_SIZE-1 -: RND_SIZE];
    win_b     = key_win[RND_SIZE-1:0];
    step_last = mode_256 ? win_b[WRD_SIZE-1:0] : win_a[WRD_SIZE-1:0];
    step_rot  = !mode_256 || !cnt[0];
    if (!mode_256)
      step_rcon = rcon_lut(4'(cnt));
    else if (cnt[0])
      step_rcon = 8'h00;
    else
      step_rcon = rcon_lut(4'(cnt >> 1));
    rk_r      = (mode_256 && cnt == CNT_SIZE'(1)) ? win_b : step_key;
    nr        = mode_256 ? CNT_SIZE'(NR_256) : CNT_SIZE'(NR_128);
    last_rnd  = (cnt == nr);
  end

  aes_key_step u_key_step (
    .prev_key (win_a),
    .last_word(step_last),
    .rot_en   (step_rot),
    .rcon     (step_rcon),
    .next_key (step_key)
  );

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int unsigned i = 0; i < 16; i++)
      sb[RND_SIZE-1-8*i -: 8] = sbox(state_reg[RND_SIZE-1-8*i -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[RND_SIZE-1-8*(4*c+r) -: 8] = sb[RND_SIZE-1-8*(4*((c+r)%4)+r) -: 8];
    for (int unsigned c = 0; c < 4; c++)
      mc[RND_SIZE-1-32*c -: 32] = mix_column(sr[RND_SIZE-1-32*c -: 32]);
    rnd_out = (last_rnd ? sr : mc) ^ rk_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      state_reg     <= '0;
      key_win       <= '0;
      mode_256      <= 1'b0;
      cnt           <= '0;
      o_valid       <= 1'b0;
      o_cypher_text <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            state_reg <= i_rnd_text ^ rk0;
            key_win   <= {rk0, key_lo};
            mode_256  <= sel_256;
            cnt       <= CNT_SIZE'(1);
            state     <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= rnd_out;
          if (!mode_256)
            key_win <= {rk_r, win_b};
          else if (cnt != CNT_SIZE'(1))
            key_win <= {win_b, rk_r};
          if (last_rnd) begin
            o_cypher_text <= rnd_out;
            o_valid       <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
